// File: rtl/i2c_bus_access_ctrl_pkg.sv
// i2c_bus_access_ctrl_pkg
//   Shared I2C bus timing constants and helpers for the bus access controller.
//   Rise/fall periods and the bus-free time tBUF are given per mode in ns.
//   buf_cycles() turns tBUF into clk cycles: rounded up, minimum 1.
package i2c_bus_access_ctrl_pkg;

  // standard mode
  localparam int T_R_SM_NS   = 1000;
  localparam int T_F_SM_NS   = 300;
  localparam int T_BUF_SM_NS = 4700;
  // fast mode
  localparam int T_R_FM_NS   = 300;
  localparam int T_F_FM_NS   = 300;
  localparam int T_BUF_FM_NS = 1300;

  function automatic int buf_cycles(input int us, input int mode);
    int ns;
    int c;
    ns = (mode == 1) ? T_BUF_FM_NS : T_BUF_SM_NS;
    c  = (ns * us + 999) / 1000;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/i2c_bus_access_ctrl_if.sv
// i2c_bus_access_ctrl_if
//   Requester / bus-monitor / engine signals of the bus access controller.
//   master : the controller (reads requests and bus status, drives grants)
//   slave  : requester front ends, bus-busy detector and master engine
//   req/done/lost/gnt are one bit per requester; gnt_idx is the grant index.
interface i2c_bus_access_ctrl_if #(
  parameter int NREQ = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic            bby;
  logic            sta;
  logic            sto;
  logic            arb_lost;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            mst_en;
  logic [NREQ-1:0] lost;
  logic            bus_free;

  modport master (
    input  req, done, bby, sta, sto, arb_lost,
    output gnt, gnt_idx, mst_en, lost, bus_free
  );

  modport slave (
    output req, done, bby, sta, sto, arb_lost,
    input  gnt, gnt_idx, mst_en, lost, bus_free
  );
endinterface

// File: rtl/i2c_bus_access_ctrl_rr_pick.sv
// i2c_rr_pick
//   Combinational round-robin picker.
//   req        : request vector
//   ptr        : index where the search starts
//   win_vld    : some request is set
//   win_idx    : first set request at or after ptr (wrapping)
//   win_onehot : one-hot form of win_idx (zero when !win_vld)
module i2c_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            win_vld,
  output logic [IW-1:0]   win_idx,
  output logic [NREQ-1:0] win_onehot
);

  int k;

  always_comb begin
    win_vld    = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    k          = 0;
    // scan from the farthest offset down so the nearest hit to ptr is kept
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NREQ;
      if (req[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
    if (win_vld) win_onehot[win_idx] = 1'b1;
  end

endmodule

// File: rtl/i2c_bus_access_ctrl.sv
// i2c_bus_access_ctrl
//   Arbitrates local I2C requesters for the shared master engine. Follows bus
//   ownership from the bus-busy detector, enforces tBUF after the bus goes
//   free, grants one requester at a time round-robin, revokes on arb loss.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requests/done/bus status in; gnt, gnt_idx, mst_en, lost,
//              bus_free out (see i2c_bus_access_ctrl_if)
//
//   state  | meaning
//   S_WAIT | bus not known free
//   S_BUF  | tBUF countdown
//   S_IDLE | bus free, no owner
//   S_OWN  | grant held
module i2c_bus_access_ctrl
  import i2c_bus_access_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int US       = 50,
  parameter int I2C_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_bus_access_ctrl_if.master bus
);

  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BUF_CYC = buf_cycles(US, I2C_MODE);
  localparam int CW      = $clog2(BUF_CYC + 1);

  localparam logic [1:0] ENC_WAIT = 2'd0;
  localparam logic [1:0] ENC_BUF  = 2'd1;
  localparam logic [1:0] ENC_IDLE = 2'd2;
  localparam logic [1:0] ENC_OWN  = 2'd3;

  typedef enum logic [1:0] {
    S_WAIT = ENC_WAIT,
    S_BUF  = ENC_BUF,
    S_IDLE = ENC_IDLE,
    S_OWN  = ENC_OWN
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [NREQ-1:0] gnt, gnt_n;
  logic [IW-1:0]   gnt_idx, gnt_idx_n;
  logic [NREQ-1:0] lost, lost_n;
  logic            bus_free;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;

  // STOP is implied by bby falling; the pulse itself carries no extra info here
  logic unused_sto;
  assign unused_sto = bus.sto;

  i2c_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req        (bus.req),
    .ptr        (ptr),
    .win_vld    (win_vld),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_WAIT;
      cnt      <= '0;
      ptr      <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      lost     <= '0;
      bus_free <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      gnt_idx  <= gnt_idx_n;
      lost     <= lost_n;
      bus_free <= (state_n == S_IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    gnt_n     = gnt;
    gnt_idx_n = gnt_idx;
    lost_n    = '0;
    unique case (state)
      S_WAIT: begin
        if (!bus.bby) begin
          state_n = S_BUF;
          cnt_n   = CW'(BUF_CYC - 1);
        end
      end
      S_BUF: begin
        if (bus.bby || bus.sta) state_n = S_WAIT;
        else if (cnt == '0)     state_n = S_IDLE;
        else                    cnt_n   = cnt - 1'b1;
      end
      S_IDLE: begin
        // foreign START beats a same-cycle local request
        if (bus.bby || bus.sta) begin
          state_n = S_WAIT;
        end else if (win_vld) begin
          state_n   = S_OWN;
          gnt_n     = win_onehot;
          gnt_idx_n = win_idx;
          ptr_n     = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      S_OWN: begin
        if (bus.arb_lost) begin
          state_n         = S_WAIT;
          gnt_n           = '0;
          lost_n[gnt_idx] = 1'b1;
        end else if (bus.done[gnt_idx] || !bus.req[gnt_idx]) begin
          state_n = S_WAIT;
          gnt_n   = '0;
        end
      end
      default: state_n = S_WAIT;
    endcase
  end

  assign bus.gnt      = gnt;
  assign bus.gnt_idx  = gnt_idx;
  assign bus.mst_en   = |gnt;
  assign bus.lost     = lost;
  assign bus.bus_free = bus_free;

endmodule

// File: doc/i2c_bus_access_ctrl.md
# i2c_bus_access_ctrl

Arbitrates local I2C master requesters for the single shared master engine and bus. Tracks bus ownership from the existing bus-busy detector (`bby`, `sta`, `sto`) and enforces the bus-free time tBUF after every STOP. Grants one requester at a time with round-robin fairness and revokes the grant on arbitration loss. Sits between the requester-side command front ends and the bit-level master engine.

## Interface
- `NREQ`, 4: number of requesters; 2..16.
- `US`, 50: clk cycles per microsecond.
- `I2C_MODE`, 0: 0 = standard mode (tBUF 4.7 µs), 1 = fast mode (tBUF 1.3 µs).
- `BUF_CYC`, derived: tBUF·US, rounded up, minimum 1. Equals 235 (mode 0) or 65 (mode 1) at US=50.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  NREQ  level request per requester; held until `done` or `lost`.
- `done`  in  NREQ  one-cycle pulse: the granted requester's transaction has issued its STOP.
- `bby`  in  1  bus busy, from the bus-busy detector.
- `sta`  in  1  START-detected pulse.
- `sto`  in  1  STOP-detected pulse.
- `arb_lost`  in  1  one-cycle pulse from the master engine: arbitration lost.
- `gnt`  out  NREQ  one-hot grant; all zero when nobody owns the engine.
- `gnt_idx`  out  $clog2(NREQ)  index of the current or last grant.
- `mst_en`  out  1  enables the master engine; equals |gnt.
- `lost`  out  NREQ  one-cycle pulse to the requester whose grant was revoked by `arb_lost`.
- `bus_free`  out  1  high in S_IDLE.

## Operation
- States:
  - **S_WAIT**: bus not known free.
  - **S_BUF**: tBUF countdown.
  - **S_IDLE**: bus free, no owner.
  - **S_OWN**: grant held.
- S_WAIT: when `bby`==0, go to S_BUF and set `cnt` = BUF_CYC-1.
- S_BUF: if `bby`==1 or `sta`, go to S_WAIT. Otherwise, if `cnt`==0, go to S_IDLE; else decrement `cnt`.
- S_IDLE: if `bby`==1 or `sta`, go to S_WAIT with no grant. Otherwise, if `req`≠0, pick the round-robin winner, register `gnt`/`gnt_idx`, and go to S_OWN.
- Round-robin pointer:
  - The search starts at `ptr`.
  - On grant, `ptr` = winner+1, modulo NREQ.
  - After reset, `ptr`=0.
- S_OWN, exits in priority order:
  1. `arb_lost`: clear `gnt`, pulse `lost[gnt_idx]`, go to S_WAIT.
  2. `done[gnt_idx]`: clear `gnt`, go to S_WAIT.
  3. `req[gnt_idx]`==0 (requester withdrew): clear `gnt`, go to S_WAIT.
- `done` bits of non-granted requesters are ignored in every state.
- Requests are never queued. A requester that is not granted simply keeps `req` high.
- `cnt` width is $clog2(BUF_CYC+1). It never wraps: a decrement happens only when `cnt`>0.

## Timing
- Reset values:
  - state = S_WAIT.
  - `gnt`=0, `gnt_idx`=0, `mst_en`=0, `lost`=0, `bus_free`=0, `cnt`=0, `ptr`=0.
- Reset mid-grant drops `gnt` asynchronously. On release of reset, the full tBUF is re-enforced before any grant.
- Let t be the first S_WAIT cycle with `bby`==0 sampled:
  - S_BUF occupies cycles t+1 .. t+BUF_CYC.
  - S_IDLE occupies cycle t+BUF_CYC+1.
  - Earliest `gnt` is registered at t+BUF_CYC+2.
- Request-to-grant latency from S_IDLE is 1 cycle.
- After `done` or `arb_lost` in cycle n, `gnt` and `mst_en` are low at n+1 and `lost` pulses at n+1.
- Simultaneous events:
  - `req` arriving in the same cycle as `sta` in S_IDLE: no grant; go to S_WAIT.
  - `arb_lost` and `done` in the same cycle: treated as `arb_lost`.
- All outputs are registered, except `mst_en`, which is the OR of registered `gnt`.

## Structure
- The shared timing include gains `T_BUF_NS` per mode. BUF_CYC is computed there from `US` and `I2C_MODE`, alongside the existing rise/fall periods.
- Sub-module `i2c_rr_pick`, purely combinational:
  - Inputs: `req`, `ptr`.
  - Outputs: `win_vld`, `win_idx`, `win_onehot`.
  - Instantiated once.
- State encoding is local to the block, in localparams.

## Test plan
- **Reset then free bus**: NREQ=4, mode 1, US=50, `req`=0001 held from reset release, `bby`=0 → `gnt`=0001 exactly 67 cycles after the first sampled `bby`=0 (65 + 2).
- **Round robin**: `req`=1111 held; each grant ends with `done` followed by a `sto`/`bby` low sequence → grant order 0,1,2,3,0, each grant separated by ≥65 S_BUF cycles.
- **Foreign traffic**:
  - `sta` injected at S_BUF cycle 30 → back to S_WAIT.
  - `bby` drops at cycle k → `gnt` at k+67, not earlier.
- **Arbitration loss**: `gnt`=0010 plus `arb_lost` pulse → next cycle `gnt`=0, `lost`=0010 for exactly one cycle, state S_WAIT.
- **Async reset mid-grant**: `rst` asserted while `gnt`=0100 → `gnt`=0 immediately without a clock edge; after release, the next grant is delayed by the full BUF_CYC.
- **Withdraw and stray done**:
  - `req[1]` drops while granted, with no `done` → `gnt` clears next cycle.
  - `done[3]` pulsed while `gnt`=0001 → no effect.
